watch_ctrl: RTL and testbench
=============================

Name: watch_ctrl

Overview:
- Controller for the HH:MM:SS watch datapath.
- Generates the 1 Hz tick from the system clock and sequences RUN versus time-set modes from two push buttons.
- Drives a 24-hour hours:minutes:seconds counter.
- Sits between the board buttons/clock and the display driver; outputs are registered binary fields.

Parameters:
- CLK_DIV, 50000000: clk cycles per second; must be ≥ 2 and even.
- HR_MAX, 23: last hours value before wrap.
- MS_MAX, 59: last minutes/seconds value before wrap.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- mode_btn  in  1  mode button level; already synchronised and debounced.
- inc_btn  in  1  increment button level; already synchronised and debounced.
- hrs  out  5  hours, 0..HR_MAX.
- mins  out  6  minutes, 0..MS_MAX.
- secs  out  6  seconds, 0..MS_MAX.
- mode  out  2  current state: 00 RUN, 01 SET_HRS, 10 SET_MINS, 11 SET_SECS.
- sec_tick  out  1  one-cycle pulse marking a seconds advance in RUN.

Behaviour:
- Reset (rst=0, asynchronous):
  - hrs, mins, secs, prescaler = 0; mode = RUN; sec_tick = 0.
  - Button history registers = 1, so a button held through reset release gives no press until released and pressed again.
  - Reset mid-set: returns to RUN at 00:00:00; partial edits are lost.
- Press detect: press = btn & ~btn_q. One press per rising edge, regardless of hold length.
- Prescaler (RUN only):
  - Counts 0..CLK_DIV-1 and wraps.
  - sec_tick = 1 in the cycle where the prescaler equals CLK_DIV-1 and mode is RUN.
  - In any SET state the prescaler is cleared and held at 0.
  - On return to RUN, the first sec_tick occurs exactly CLK_DIV cycles after the transition edge.
- FSM transitions on mode press: RUN -> SET_HRS -> SET_MINS -> SET_SECS -> RUN. No other transitions.
- RUN counting, applied on the edge following the sec_tick cycle:
  - secs increments; secs = MS_MAX wraps to 0 and carries into mins.
  - mins = MS_MAX with carry wraps to 0 and carries into hrs.
  - hrs = HR_MAX with carry wraps to 0.
  - 23:59:59 -> 00:00:00 in one step.
- SET counting, on inc press:
  - The selected field (hrs/mins/secs per state) increments modulo (its MAX+1).
  - No carry into other fields; other fields hold.
  - inc press in RUN is ignored.
- Simultaneous events:
  - mode press and inc press in the same cycle: mode wins, inc is discarded.
  - sec_tick and mode press in the same cycle (RUN): the time advance is applied and the state moves to SET_HRS on the same edge.
- Field values never exceed their MAX; no out-of-range state is reachable.
- Latency: all outputs registered. Field updates are visible one cycle after the press or tick cycle. mode changes one cycle after the press cycle.

Optional Feature:
- Macro: WATCH_BLINK_EN.
- When defined:
  - Adds output port blink (1 bit).
  - In SET states, blink toggles every CLK_DIV/2 cycles, driven by its own half-second counter (the prescaler is held in SET states).
  - blink is 0 in RUN.
  - The blink counter and blink reset to 0 and restart from 0 on every state change.
  - The display blanks the selected field while blink = 1.
- When undefined: no blink port and no blink counter. All other behaviour is identical.

Decomposition:
- Package watch_pkg:
  - mode encoding (RUN/SET_HRS/SET_MINS/SET_SECS) as a 2-bit typedef;
  - HR_W = 5 and MS_W = 6 width constants;
  - default HR_MAX/MS_MAX constants.
- Sub-module hms_counter: the hrs/mins/secs datapath.
  - Inputs: clk, rst, tick, inc_hrs, inc_mins, inc_secs.
  - Outputs: hrs, mins, secs.
  - Implements the wrap/carry rules; tick carries, inc_* do not.
- watch_ctrl contains the prescaler, press detect, FSM and optional blink logic, and instantiates hms_counter.

Test Plan (CLK_DIV = 4):
- Reset release, buttons 0 -> sec_tick every 4th cycle. secs reads 1 after the first tick, 59 after 59 ticks, then mins=1, secs=0 on the 60th.
- Preload via set to 23:59:59, return to RUN, one tick -> 00:00:00 with a single output change.
- mode press ×1, inc press ×25 -> hrs = 1 (wraps 23 -> 0); mins and secs unchanged; no sec_tick while in SET.
- mode and inc press in the same cycle from SET_MINS -> mode = SET_SECS; mins unchanged.
- inc_btn held high for 20 cycles in SET_SECS -> secs advances by exactly 1. Button held through reset release -> no press registered.
- rst pulsed low mid-cycle while in SET_MINS at 12:34:56 -> immediately 00:00:00, mode = RUN. With WATCH_BLINK_EN, blink = 0 in RUN and toggles every 2 cycles in SET states.

Source files
------------

// File: rtl/watch_pkg.sv
// -----------------------------------------------------------------------------
// watch_pkg
// Shared definitions for the HH:MM:SS watch controller:
//   - mode_e    : 2-bit mode encoding (RUN / SET_HRS / SET_MINS / SET_SECS)
//   - HR_W/MS_W : field widths for hours and minutes/seconds
//   - HR_MAX_DEF/MS_MAX_DEF : default last value of each field before wrap
//   - next_mode : fixed mode-button sequence RUN->HRS->MINS->SECS->RUN
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package watch_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'b00,
        MODE_SET_HRS  = 2'b01,
        MODE_SET_MINS = 2'b10,
        MODE_SET_SECS = 2'b11
    } mode_e;

    localparam int HR_W = 5;
    localparam int MS_W = 6;

    localparam int HR_MAX_DEF = 23;
    localparam int MS_MAX_DEF = 59;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_RUN:      next_mode = MODE_SET_HRS;
            MODE_SET_HRS:  next_mode = MODE_SET_MINS;
            MODE_SET_MINS: next_mode = MODE_SET_SECS;
            default:       next_mode = MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/hms_counter.sv
// -----------------------------------------------------------------------------
// hms_counter
// 24-hour hours:minutes:seconds datapath.
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active low
//   tick      in   one-second advance; carries secs -> mins -> hrs
//   inc_hrs   in   increment hours only (modulo HR_MAX+1, no carry)
//   inc_mins  in   increment minutes only (modulo MS_MAX+1, no carry)
//   inc_secs  in   increment seconds only (modulo MS_MAX+1, no carry)
//   hrs       out  registered hours,   0..HR_MAX
//   mins      out  registered minutes, 0..MS_MAX
//   secs      out  registered seconds, 0..MS_MAX
// The controller never asserts tick together with an inc_*; tick has
// priority should that ever happen.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module hms_counter
    import watch_pkg::*;
#(
    parameter int HR_MAX = HR_MAX_DEF,
    parameter int MS_MAX = MS_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic            inc_hrs,
    input  logic            inc_mins,
    input  logic            inc_secs,
    output logic [HR_W-1:0] hrs,
    output logic [MS_W-1:0] mins,
    output logic [MS_W-1:0] secs
);

    localparam logic [HR_W-1:0] HR_LAST = HR_W'(HR_MAX);
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_MAX);

    logic [HR_W-1:0] hrs_q,  hrs_d;
    logic [MS_W-1:0] mins_q, mins_d;
    logic [MS_W-1:0] secs_q, secs_d;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise any path that skips an assignment infers a latch.
        hrs_d  = hrs_q;
        mins_d = mins_q;
        secs_d = secs_q;

        if (tick) begin
            if (secs_q == MS_LAST) begin
                secs_d = '0;
                if (mins_q == MS_LAST) begin
                    mins_d = '0;
                    hrs_d  = (hrs_q == HR_LAST) ? '0 : hrs_q + HR_W'(1);
                end else begin
                    mins_d = mins_q + MS_W'(1);
                end
            end else begin
                secs_d = secs_q + MS_W'(1);
            end
        end else begin
            if (inc_hrs) begin
                hrs_d = (hrs_q == HR_LAST) ? '0 : hrs_q + HR_W'(1);
            end
            if (inc_mins) begin
                mins_d = (mins_q == MS_LAST) ? '0 : mins_q + MS_W'(1);
            end
            if (inc_secs) begin
                secs_d = (secs_q == MS_LAST) ? '0 : secs_q + MS_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge value; these are plain flops, not a memory, so
    // they all take the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hrs_q  <= '0;
            mins_q <= '0;
            secs_q <= '0;
        end else begin
            hrs_q  <= hrs_d;
            mins_q <= mins_d;
            secs_q <= secs_d;
        end
    end

    assign hrs  = hrs_q;
    assign mins = mins_q;
    assign secs = secs_q;

endmodule

// File: rtl/watch_ctrl.sv
// -----------------------------------------------------------------------------
// watch_ctrl
// Watch controller: 1 Hz prescaler, button press detect, RUN/SET mode FSM,
// and the hms_counter datapath.
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active low
//   mode_btn  in   mode button level (synchronised, debounced)
//   inc_btn   in   increment button level (synchronised, debounced)
//   hrs       out  hours   0..HR_MAX
//   mins      out  minutes 0..MS_MAX
//   secs      out  seconds 0..MS_MAX
//   mode      out  00 RUN, 01 SET_HRS, 10 SET_MINS, 11 SET_SECS
//   blink     out  (only with WATCH_BLINK_EN) half-second blink in SET states
//   sec_tick  out  one-cycle pulse in the cycle before a seconds advance
// Optional feature macro: WATCH_BLINK_EN adds the blink port and its counter.
// CLK_DIV must be >= 2 and even.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module watch_ctrl
    import watch_pkg::*;
#(
    parameter int CLK_DIV = 50000000,
    parameter int HR_MAX  = HR_MAX_DEF,
    parameter int MS_MAX  = MS_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode_btn,
    input  logic            inc_btn,
    output logic [HR_W-1:0] hrs,
    output logic [MS_W-1:0] mins,
    output logic [MS_W-1:0] secs,
    output logic [1:0]      mode,
`ifdef WATCH_BLINK_EN
    output logic            blink,
`endif
    output logic            sec_tick
);

    localparam int             PW         = $clog2(CLK_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_DIV - 1);

    mode_e          mode_q, mode_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic           sec_tick_q, sec_tick_d;
    logic           mode_btn_q, mode_btn_d;
    logic           inc_btn_q, inc_btn_d;

    logic           mode_press;
    logic           inc_press;
    logic           inc_ok;
    logic           inc_hrs, inc_mins, inc_secs;

    always_comb begin
        mode_btn_d = mode_btn;
        inc_btn_d  = inc_btn;

        mode_press = mode_btn & ~mode_btn_q;
        inc_press  = inc_btn  & ~inc_btn_q;

        mode_d = mode_press ? next_mode(mode_q) : mode_q;

        // A mode press in the same cycle swallows the inc press.
        inc_ok   = inc_press & ~mode_press;
        inc_hrs  = inc_ok && (mode_q == MODE_SET_HRS);
        inc_mins = inc_ok && (mode_q == MODE_SET_MINS);
        inc_secs = inc_ok && (mode_q == MODE_SET_SECS);

        // Only count while staying in RUN; entering or leaving RUN leaves the
        // prescaler at 0 so the first tick after SET lands a full period later.
        if (mode_q == MODE_RUN && mode_d == MODE_RUN) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        end else begin
            presc_d = '0;
        end

        // Registered tick: high exactly while presc_q == CLK_DIV-1 in RUN.
        sec_tick_d = (mode_d == MODE_RUN) && (presc_d == PRESC_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q     <= MODE_RUN;
            presc_q    <= '0;
            sec_tick_q <= 1'b0;
            // History starts high so a button held through reset needs a
            // release before it counts as a press.
            mode_btn_q <= 1'b1;
            inc_btn_q  <= 1'b1;
        end else begin
            mode_q     <= mode_d;
            presc_q    <= presc_d;
            sec_tick_q <= sec_tick_d;
            mode_btn_q <= mode_btn_d;
            inc_btn_q  <= inc_btn_d;
        end
    end

    hms_counter #(
        .HR_MAX (HR_MAX),
        .MS_MAX (MS_MAX)
    ) u_hms (
        .clk      (clk),
        .rst      (rst),
        .tick     (sec_tick_q),
        .inc_hrs  (inc_hrs),
        .inc_mins (inc_mins),
        .inc_secs (inc_secs),
        .hrs      (hrs),
        .mins     (mins),
        .secs     (secs)
    );

    assign mode     = mode_q;
    assign sec_tick = sec_tick_q;

`ifdef WATCH_BLINK_EN
    localparam int             HALF      = CLK_DIV / 2;
    localparam int             BW        = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [BW-1:0]  BLINK_LAST = BW'(HALF - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        // Restart the half-second phase on every state change and keep it
        // parked at 0 while in RUN.
        if (mode_d == MODE_RUN || mode_d != mode_q) begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign blink = blink_q;
`endif

endmodule

// File: tb/tb_watch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_watch_ctrl
// Directed bench for watch_ctrl with CLK_DIV = 4. Inputs are driven and
// outputs sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_watch_ctrl;

    logic       clk;
    logic       rst;
    logic       mode_btn;
    logic       inc_btn;
    logic [4:0] hrs;
    logic [5:0] mins;
    logic [5:0] secs;
    logic [1:0] mode;
    logic       sec_tick;
`ifdef WATCH_BLINK_EN
    logic       blink;
`endif

    int n_cmp;
    int n_bad;
    int ticks_seen;

    watch_ctrl #(
        .CLK_DIV (4),
        .HR_MAX  (23),
        .MS_MAX  (59)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode_btn (mode_btn),
        .inc_btn  (inc_btn),
        .hrs      (hrs),
        .mins     (mins),
        .secs     (secs),
        .mode     (mode),
`ifdef WATCH_BLINK_EN
        .blink    (blink),
`endif
        .sec_tick (sec_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: return 1 ns after the rising edge, counting observed ticks.
    task automatic step();
        @(posedge clk);
        #1;
        if (sec_tick === 1'b1) ticks_seen++;
    endtask

    task automatic press_mode();
        mode_btn = 1'b1;
        step();
        mode_btn = 1'b0;
        step();
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            inc_btn = 1'b1;
            step();
            inc_btn = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mode_btn = 1'b0;
        inc_btn = 1'b0;
        repeat (3) step();
        n_cmp++; if ({hrs, mins, secs} !== 17'd0) begin n_bad++; $display("FAIL reset_time: got %0d:%0d:%0d want 0:0:0", hrs, mins, secs); end
        n_cmp++; if (mode !== 2'd0) begin n_bad++; $display("FAIL reset_mode: got %0d want 0", mode); end
        n_cmp++; if (sec_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %0b want 0", sec_tick); end
        rst = 1'b1;
    endtask

    task automatic test_run_count();
        int t0;
        inc_btn = 1'b1;
        step();
        inc_btn = 1'b0;
        step();
        n_cmp++; if ({hrs, mins, secs} !== 17'd0 || mode !== 2'd0) begin n_bad++; $display("FAIL inc_in_run: got %0d:%0d:%0d mode %0d want 0:0:0 mode 0", hrs, mins, secs, mode); end
        n_cmp++; if (sec_tick !== 1'b0) begin n_bad++; $display("FAIL tick_early: got %0b want 0", sec_tick); end
        step();
        n_cmp++; if (sec_tick !== 1'b1) begin n_bad++; $display("FAIL first_tick: got %0b want 1", sec_tick); end
        step();
        n_cmp++; if (secs !== 6'd1 || sec_tick !== 1'b0) begin n_bad++; $display("FAIL first_secs: got secs %0d tick %0b want 1 0", secs, sec_tick); end
        t0 = ticks_seen;
        repeat (58 * 4) step();
        n_cmp++; if (secs !== 6'd59 || mins !== 6'd0) begin n_bad++; $display("FAIL secs_59: got %0d:%0d want 0:59", mins, secs); end
        n_cmp++; if (ticks_seen - t0 !== 58) begin n_bad++; $display("FAIL tick_rate: got %0d ticks want 58", ticks_seen - t0); end
        repeat (4) step();
        n_cmp++; if (mins !== 6'd1 || secs !== 6'd0 || hrs !== 5'd0) begin n_bad++; $display("FAIL secs_carry: got %0d:%0d:%0d want 0:1:0", hrs, mins, secs); end
    endtask

    task automatic test_day_wrap();
        press_mode();
        press_inc(23);
        press_mode();
        press_inc(58);
        press_mode();
        press_inc(59);
        n_cmp++; if (hrs !== 5'd23 || mins !== 6'd59 || secs !== 6'd59 || mode !== 2'd3) begin n_bad++; $display("FAIL preload: got %0d:%0d:%0d mode %0d want 23:59:59 mode 3", hrs, mins, secs, mode); end
        mode_btn = 1'b1;
        step();
        mode_btn = 1'b0;
        n_cmp++; if (mode !== 2'd0) begin n_bad++; $display("FAIL back_to_run: got %0d want 0", mode); end
        step();
        step();
        n_cmp++; if (sec_tick !== 1'b0 || secs !== 6'd59) begin n_bad++; $display("FAIL run_resume_early: got tick %0b secs %0d want 0 59", sec_tick, secs); end
        step();
        n_cmp++; if (sec_tick !== 1'b1 || {hrs, mins, secs} !== {5'd23, 6'd59, 6'd59}) begin n_bad++; $display("FAIL run_resume_tick: got tick %0b %0d:%0d:%0d want 1 23:59:59", sec_tick, hrs, mins, secs); end
        step();
        n_cmp++; if ({hrs, mins, secs} !== 17'd0) begin n_bad++; $display("FAIL day_wrap: got %0d:%0d:%0d want 0:0:0", hrs, mins, secs); end
    endtask

    task automatic test_set_hrs_wrap();
        int t0;
        t0 = ticks_seen;
        press_mode();
        n_cmp++; if (mode !== 2'd1) begin n_bad++; $display("FAIL enter_set_hrs: got %0d want 1", mode); end
        press_inc(23);
        n_cmp++; if (hrs !== 5'd23) begin n_bad++; $display("FAIL set_hrs_23: got %0d want 23", hrs); end
        press_inc(1);
        n_cmp++; if (hrs !== 5'd0) begin n_bad++; $display("FAIL set_hrs_wrap: got %0d want 0", hrs); end
        press_inc(1);
        n_cmp++; if (hrs !== 5'd1 || mins !== 6'd0 || secs !== 6'd0) begin n_bad++; $display("FAIL set_hrs_25: got %0d:%0d:%0d want 1:0:0", hrs, mins, secs); end
        n_cmp++; if (ticks_seen !== t0) begin n_bad++; $display("FAIL tick_in_set: got %0d ticks want 0", ticks_seen - t0); end
    endtask

    task automatic test_simultaneous();
        press_mode();
        press_inc(5);
        n_cmp++; if (mins !== 6'd5 || mode !== 2'd2) begin n_bad++; $display("FAIL set_mins: got mins %0d mode %0d want 5 2", mins, mode); end
        mode_btn = 1'b1;
        inc_btn = 1'b1;
        step();
        n_cmp++; if (mode !== 2'd3 || mins !== 6'd5 || secs !== 6'd0) begin n_bad++; $display("FAIL mode_beats_inc: got mode %0d mins %0d secs %0d want 3 5 0", mode, mins, secs); end
        mode_btn = 1'b0;
        inc_btn = 1'b0;
        step();
    endtask

    task automatic test_hold();
        inc_btn = 1'b1;
        repeat (20) step();
        inc_btn = 1'b0;
        step();
        n_cmp++; if (secs !== 6'd1 || mins !== 6'd5 || hrs !== 5'd1) begin n_bad++; $display("FAIL held_inc: got %0d:%0d:%0d want 1:5:1", hrs, mins, secs); end
    endtask

    task automatic test_reset_hold();
        mode_btn = 1'b1;
        inc_btn = 1'b1;
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (mode !== 2'd0 || {hrs, mins, secs} !== 17'd0) begin n_bad++; $display("FAIL held_through_reset: got mode %0d %0d:%0d:%0d want 0 0:0:0", mode, hrs, mins, secs); end
        mode_btn = 1'b0;
        inc_btn = 1'b0;
        step();
        n_cmp++; if (sec_tick !== 1'b1) begin n_bad++; $display("FAIL tick_before_press: got %0b want 1", sec_tick); end
        mode_btn = 1'b1;
        step();
        n_cmp++; if (mode !== 2'd1 || secs !== 6'd1) begin n_bad++; $display("FAIL tick_and_mode: got mode %0d secs %0d want 1 1", mode, secs); end
        mode_btn = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_set();
        press_inc(12);
        press_mode();
        press_inc(34);
        press_mode();
        press_inc(55);
        press_mode();
        press_mode();
        press_mode();
        n_cmp++; if (mode !== 2'd2 || hrs !== 5'd12 || mins !== 6'd34 || secs !== 6'd56) begin n_bad++; $display("FAIL preset_12_34_56: got mode %0d %0d:%0d:%0d want 2 12:34:56", mode, hrs, mins, secs); end
        #3;
        rst = 1'b0;
        #1;
        n_cmp++; if (mode !== 2'd0 || {hrs, mins, secs} !== 17'd0 || sec_tick !== 1'b0) begin n_bad++; $display("FAIL async_reset: got mode %0d %0d:%0d:%0d tick %0b want 0 0:0:0 0", mode, hrs, mins, secs, sec_tick); end
        step();
        rst = 1'b1;
    endtask

`ifdef WATCH_BLINK_EN
    task automatic test_blink();
        n_cmp++; if (blink !== 1'b0) begin n_bad++; $display("FAIL blink_run: got %0b want 0", blink); end
        step();
        mode_btn = 1'b1;
        step();
        mode_btn = 1'b0;
        n_cmp++; if (blink !== 1'b0 || mode !== 2'd1) begin n_bad++; $display("FAIL blink_enter: got blink %0b mode %0d want 0 1", blink, mode); end
        step();
        step();
        n_cmp++; if (blink !== 1'b1) begin n_bad++; $display("FAIL blink_on: got %0b want 1", blink); end
        step();
        step();
        n_cmp++; if (blink !== 1'b0) begin n_bad++; $display("FAIL blink_off: got %0b want 0", blink); end
        step();
        step();
        n_cmp++; if (blink !== 1'b1) begin n_bad++; $display("FAIL blink_on2: got %0b want 1", blink); end
        mode_btn = 1'b1;
        step();
        mode_btn = 1'b0;
        n_cmp++; if (blink !== 1'b0 || mode !== 2'd2) begin n_bad++; $display("FAIL blink_restart: got blink %0b mode %0d want 0 2", blink, mode); end
        step();
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        ticks_seen = 0;
        test_reset();
        test_run_count();
        test_day_wrap();
        test_set_hrs_wrap();
        test_simultaneous();
        test_hold();
        test_reset_hold();
        test_reset_mid_set();
`ifdef WATCH_BLINK_EN
        test_blink();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
